// File: rtl/sisc_pkg.sv
// Shared SISC definitions: bus widths used by the control unit, datapath and
// memory, plus the memory responder state encoding.
package sisc_pkg;

  localparam int SISC_ADDR_W       = 16;
  localparam int SISC_DATA_W       = 32;
  localparam int SISC_DEFAULT_WAIT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    RESP    = 2'd2
  } mem_state_e;

endpackage

// File: rtl/sisc_mem_array.sv
// Word storage for the SISC memory: synchronous write, registered read.
// Contents are deliberately never reset.
module sisc_mem_array #(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 256,
  parameter int    IDX_W     = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The read register only moves on an actual read, so the last value holds.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sisc_mem_resp.sv
// SISC memory responder: accepts one request at a time, inserts WAIT wait
// states, then accesses the word array and pulses ack for one cycle.
module sisc_mem_resp
  import sisc_pkg::*;
#(
  parameter int    ADDR_W    = SISC_ADDR_W,
  parameter int    DATA_W    = SISC_DATA_W,
  parameter int    DEPTH     = 256,
  parameter int    WAIT      = SISC_DEFAULT_WAIT,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              rd_sel_q, rd_sel_d;

  logic              access;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              in_range;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    err_d     = err_q;
    rd_sel_d  = rd_sel_q;
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          // With no wait states the access happens on the accepting edge itself.
          if (WAIT == 0) begin
            access    = 1'b1;
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            cnt_d     = 4'd0;
            state_d   = RESP;
          end else begin
            cnt_d   = 4'(WAIT);
            state_d = WAIT_ST;
          end
        end
      end
      WAIT_ST: begin
        cnt_d = 4'(cnt_q - 4'd1);
        if (cnt_q <= 4'd1) begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_range = (33'(acc_addr) < 33'(DEPTH));
    ack_d    = access;
    if (access) begin
      err_d    = ~in_range;
      rd_sel_d = ~acc_we & in_range;
    end
    mem_we = access & acc_we & in_range;
    mem_re = access & ~acc_we & in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  sisc_mem_array #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .idx  (acc_addr[IDX_W-1:0]),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  // Writes and out-of-range accesses present zero; the selector is reset so rdata is too.
  assign rdata = rd_sel_q ? mem_rdata : '0;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sisc_mem_resp.sv
// Directed bench for sisc_mem_resp: a WAIT=2 instance for most scenarios and
// a WAIT=0 instance for the zero-wait case.
module tb_sisc_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, busy, err;

  logic        zreq = 1'b0, zwe = 1'b0;
  logic [15:0] zaddr = '0;
  logic [31:0] zwdata = '0;
  logic [31:0] zrdata;
  logic        zack, zbusy, zerr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT(2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  sisc_mem_resp #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT(0), .INIT_FILE("")) dut_z (
    .clk(clk), .rst(rst), .req(zreq), .we(zwe), .addr(zaddr), .wdata(zwdata),
    .rdata(zrdata), .ack(zack), .busy(zbusy), .err(zerr)
  );

  // One request on the WAIT=2 instance; returns in the ack cycle with the
  // number of cycles from the req cycle to ack (-1 if ack never came).
  task automatic do_access(input logic w, input logic [15:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic er,
                           output logic bz);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = 16'hFFFF; wdata = ~d;
    lat = 1;
    while (ack !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (ack !== 1'b1) lat = -1;
    rd = rdata; er = err; bz = busy;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ack !== 1'b0)    begin fails++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (err !== 1'b0)    begin fails++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    rst = 1'b0;
  endtask

  task automatic test_read_latency();
    int lat; logic [31:0] rd; logic er, bz;
    do_access(1'b1, 16'd5, 32'h1234_5678, lat, rd, er, bz);
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL write_rdata_zero: got %h expected 0", rd); end
    do_access(1'b0, 16'd5, 32'h0, lat, rd, er, bz);
    tests++; if (lat != 3)             begin fails++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
    tests++; if (rd !== 32'h1234_5678) begin fails++; $display("[TB] FAIL read5_data: got %h expected 12345678", rd); end
    tests++; if (er !== 1'b0)          begin fails++; $display("[TB] FAIL read5_err: got %b expected 0", er); end
    tests++; if (bz !== 1'b1)          begin fails++; $display("[TB] FAIL busy_in_ack: got %b expected 1", bz); end
    @(posedge clk); #1;
    tests++; if (ack !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL after_ack: got ack=%b busy=%b expected 0/0", ack, busy);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic er, bz;
    do_access(1'b1, 16'd10, 32'hDEAD_BEEF, lat, rd, er, bz);
    tests++; if (lat != 3) begin fails++; $display("[TB] FAIL write_latency: got %0d expected 3", lat); end
    do_access(1'b0, 16'd10, 32'h0, lat, rd, er, bz);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL raw_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_zero_wait();
    @(posedge clk); #1;
    zreq = 1'b1; zwe = 1'b1; zaddr = 16'd0; zwdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    zreq = 1'b0;
    tests++; if (zack !== 1'b1) begin fails++; $display("[TB] FAIL zw_write_ack: got %b expected 1", zack); end
    @(posedge clk); #1;
    zreq = 1'b1; zwe = 1'b0; zaddr = 16'd0;
    @(posedge clk); #1;
    zreq = 1'b0; zaddr = 16'd1;
    tests++; if (zack !== 1'b1)            begin fails++; $display("[TB] FAIL zw_read_ack: got %b expected 1", zack); end
    tests++; if (zbusy !== 1'b1)           begin fails++; $display("[TB] FAIL zw_busy: got %b expected 1", zbusy); end
    tests++; if (zrdata !== 32'hA5A5_A5A5) begin fails++; $display("[TB] FAIL zw_data: got %h expected a5a5a5a5", zrdata); end
    tests++; if (zerr !== 1'b0)            begin fails++; $display("[TB] FAIL zw_err: got %b expected 0", zerr); end
    @(posedge clk); #1;
    tests++; if (zack !== 1'b0 || zbusy !== 1'b0) begin
      fails++; $display("[TB] FAIL zw_after: got ack=%b busy=%b expected 0/0", zack, zbusy);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er, bz;
    do_access(1'b1, 16'd44, 32'h4444_4444, lat, rd, er, bz);
    do_access(1'b1, 16'd300, 32'h1, lat, rd, er, bz);
    tests++; if (lat != 3)     begin fails++; $display("[TB] FAIL oor_ack_latency: got %0d expected 3", lat); end
    tests++; if (er !== 1'b1)  begin fails++; $display("[TB] FAIL oor_err: got %b expected 1", er); end
    tests++; if (rd !== 32'h0) begin fails++; $display("[TB] FAIL oor_rdata: got %h expected 0", rd); end
    do_access(1'b0, 16'd44, 32'h0, lat, rd, er, bz);
    tests++; if (rd !== 32'h4444_4444) begin fails++; $display("[TB] FAIL oor_alias: got %h expected 44444444", rd); end
    tests++; if (er !== 1'b0)          begin fails++; $display("[TB] FAIL oor_err_clear: got %b expected 0", er); end
  endtask

  task automatic test_ignored_req();
    int lat; logic [31:0] rd; logic er, bz;
    int acks; logic [31:0] ack_data;
    acks = 0; ack_data = '0;
    do_access(1'b1, 16'd7, 32'h0000_0077, lat, rd, er, bz);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 16'd5;
    @(posedge clk); #1;
    we = 1'b1; addr = 16'd7; wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 14; i++) begin
      if (ack === 1'b1) begin
        acks++; ack_data = rdata; req = 1'b0;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    tests++; if (acks != 1)                  begin fails++; $display("[TB] FAIL ignored_ack_count: got %0d expected 1", acks); end
    tests++; if (ack_data !== 32'h1234_5678) begin fails++; $display("[TB] FAIL ignored_first_data: got %h expected 12345678", ack_data); end
    do_access(1'b0, 16'd7, 32'h0, lat, rd, er, bz);
    tests++; if (rd !== 32'h0000_0077) begin fails++; $display("[TB] FAIL ignored_no_write: got %h expected 00000077", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er, bz;
    int acks;
    acks = 0;
    do_access(1'b1, 16'd3, 32'h3333_3333, lat, rd, er, bz);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 16'd3; wdata = 32'hCCCC_CCCC;
    @(posedge clk); #1;
    req = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy_before: got %b expected 1", busy); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++; if (ack !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_reset_drop: got ack=%b busy=%b expected 0/0", ack, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ack === 1'b1) acks++;
      @(posedge clk); #1;
    end
    tests++; if (acks != 0) begin fails++; $display("[TB] FAIL mid_no_ack: got %0d expected 0", acks); end
    do_access(1'b0, 16'd3, 32'h0, lat, rd, er, bz);
    tests++; if (rd !== 32'h3333_3333) begin fails++; $display("[TB] FAIL mid_no_write: got %h expected 33333333", rd); end
  endtask

  task automatic test_back_to_back();
    int first, second, acks;
    first = -1; second = -1; acks = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = 16'd10;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        acks++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    tests++; if (first != 3)           begin fails++; $display("[TB] FAIL b2b_first: got %0d expected 3", first); end
    tests++; if (second - first != 4) begin fails++; $display("[TB] FAIL b2b_period: got %0d expected 4", second - first); end
    tests++; if (acks != 3)            begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 3", acks); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_zero_wait();
    test_out_of_range();
    test_ignored_req();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
